imm_encode: RTL and testbench

Immediate encoder, the inverse of the datapath's immediate sign/zero-extension stage. Takes a 32-bit value plus the 2-bit extension-op code and produces the 24-bit instruction immediate field, plus a fit flag that is set only when re-extending that field with the same code reproduces the value exactly. Used by the branch-target/fetch-redirect logic and by the test instruction generator. It is a 2-stage valid/ready pipeline.

---
 rtl/imm_pkg.sv | 23 ++
 rtl/imm_encode_if.sv | 34 +++
 rtl/imm_fit_check.sv | 42 ++++
 rtl/imm_encode.sv | 106 ++++++++++
 tb/tb_imm_encode.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Package : imm_pkg
// Desc    : Extension-op codes and immediate width shared by the immediate
//           encoder and the datapath extension stage.
// Rev     : 1.0  initial release
// ============================================================================
package imm_pkg;

    localparam int         IMM_W       = 24;

    localparam logic [1:0] EXTOP_U8    = 2'b00;
    localparam logic [1:0] EXTOP_U12   = 2'b01;
    localparam logic [1:0] EXTOP_OFF24 = 2'b10;
    localparam logic [1:0] EXTOP_ILL   = 2'b11;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic             fit;
    } imm_res_t;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_encode_if.sv
`default_nettype none
// ============================================================================
// Interface : imm_encode_if
// Desc      : Request/result valid-ready bus of the immediate encoder.
// Rev       : 1.0  initial release
// ============================================================================
interface imm_encode_if #(
    parameter int TAG_W = 4
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                in_value;
    logic [1:0]                 in_extop;
    logic [TAG_W-1:0]           in_tag;

    logic                       out_valid;
    logic                       out_ready;
    logic [imm_pkg::IMM_W-1:0]  out_imm;
    logic                       out_fit;
    logic [TAG_W-1:0]           out_tag;

    modport master (
        output in_valid, in_value, in_extop, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fit, out_tag
    );

    modport slave (
        input  in_valid, in_value, in_extop, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fit, out_tag
    );

endinterface : imm_encode_if
`default_nettype wire

// File: rtl/imm_fit_check.sv
`default_nettype none
// ============================================================================
// Module : imm_fit_check
// Desc   : Combinational value -> immediate field encoder with exact-fit flag.
// Rev    : 1.0  initial release
// ============================================================================
module imm_fit_check
    import imm_pkg::*;
(
    input  wire logic [31:0]      i_value,
    input  wire logic [1:0]       i_extop,
    output logic      [IMM_W-1:0] o_imm,
    output logic                  o_fit
);

    // Field is always the truncated slice, even when it does not fit.
    always_comb begin
        o_imm = '0;
        o_fit = 1'b0;
        case (i_extop)
            EXTOP_U8: begin
                o_imm = {16'd0, i_value[7:0]};
                o_fit = (i_value[31:8] == 24'd0);
            end
            EXTOP_U12: begin
                o_imm = {12'd0, i_value[11:0]};
                o_fit = (i_value[31:12] == 20'd0);
            end
            EXTOP_OFF24: begin
                o_imm = i_value[25:2];
                o_fit = (i_value[1:0] == 2'b00) &&
                        (i_value[31:26] == {6{i_value[25]}});
            end
            default: begin
                o_imm = '0;
                o_fit = 1'b0;
            end
        endcase
    end

endmodule : imm_fit_check
`default_nettype wire

// File: rtl/imm_encode.sv
`default_nettype none
// ============================================================================
// Module : imm_encode
// Desc   : Two-stage valid/ready immediate encoder (inverse of imm extension).
// Macro  : IMM_ENCODE_STATS_EN adds the saturating fail_count output.
// Rev    : 1.0  initial release
// ============================================================================
module imm_encode
    import imm_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    imm_encode_if.slave bus
`ifdef IMM_ENCODE_STATS_EN
    ,
    output logic [15:0] fail_count
`endif
);

    logic               r_s1_valid;
    logic [31:0]        r_s1_value;
    logic [1:0]         r_s1_extop;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_valid;
    logic [IMM_W-1:0]   r_s2_imm;
    logic               r_s2_fit;
    logic [TAG_W-1:0]   r_s2_tag;

    logic [IMM_W-1:0]   w_imm;
    logic               w_fit;
    logic               w_s2_load;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_pop;

    imm_fit_check u_fit (
        .i_value (r_s1_value),
        .i_extop (r_s1_extop),
        .o_imm   (w_imm),
        .o_fit   (w_fit)
    );

    assign w_pop      = r_s2_valid && bus.out_ready;
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready);
    // No skid buffer: S1 can only take a new request when it empties this cycle.
    assign w_in_ready = !rst && (!r_s1_valid || w_s2_load);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_value <= '0;
            r_s1_extop <= '0;
            r_s1_tag   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_value <= bus.in_value;
            r_s1_extop <= bus.in_extop;
            r_s1_tag   <= bus.in_tag;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_imm   <= '0;
            r_s2_fit   <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_imm   <= w_imm;
            r_s2_fit   <= w_fit;
            r_s2_tag   <= r_s1_tag;
        end else if (w_pop) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_imm   = r_s2_imm;
    assign bus.out_fit   = r_s2_fit;
    assign bus.out_tag   = r_s2_tag;

`ifdef IMM_ENCODE_STATS_EN
    logic [15:0] r_fail_count;

    // Counted only when a non-fitting result is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_count <= '0;
        end else if (w_pop && !r_s2_fit && (r_fail_count != 16'hFFFF)) begin
            r_fail_count <= r_fail_count + 16'd1;
        end
    end

    assign fail_count = r_fail_count;
`endif

endmodule : imm_encode
`default_nettype wire

// File: tb/tb_imm_encode.sv
`default_nettype none
// ============================================================================
// Module : tb_imm_encode
// Desc   : Scoreboard testbench for imm_encode (optionally IMM_ENCODE_STATS_EN).
// Rev    : 1.0  initial release
// ============================================================================
module tb_imm_encode;

    typedef struct packed {
        logic [23:0] imm;
        logic        fit;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_out;
    int   exp_fail;
    exp_t q[$];

`ifdef IMM_ENCODE_STATS_EN
    logic [15:0] fail_count;
`endif

    imm_encode_if #(.TAG_W(4)) bus ();

    imm_encode #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef IMM_ENCODE_STATS_EN
        ,
        .fail_count (fail_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v, input logic [1:0] e, input logic [3:0] t);
        exp_t r;
        r.tag = t;
        r.imm = '0;
        r.fit = 1'b0;
        case (e)
            2'd0: begin r.imm = {16'h0, v[7:0]};  r.fit = (v < 32'd256);  end
            2'd1: begin r.imm = {12'h0, v[11:0]}; r.fit = (v < 32'd4096); end
            2'd2: begin
                r.imm = v[25:2];
                r.fit = ({{6{v[25]}}, v[25:2], 2'b00} == v);
            end
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: compare every consumed result, and held fields during stalls.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_fail = 0;
        end else begin
            if (bus.out_valid && !bus.out_ready && q.size() > 0) begin
                check("hold_imm", bus.out_imm, q[0].imm);
                check("hold_tag", bus.out_tag, q[0].tag);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out_tag", bus.out_tag, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("imm", bus.out_imm, e.imm);
                    check("fit", bus.out_fit, e.fit);
                    check("tag", bus.out_tag, e.tag);
                    if (!e.fit) exp_fail++;
                end
                n_out++;
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [1:0] e, input logic [3:0] t,
                        input logic [23:0] ximm, input logic xfit);
        bit   acc;
        exp_t x;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_extop = e;
        bus.in_tag   = t;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin acc = 1'b1; break; end
        end
        check("send_accepted", acc, 1);
        if (acc) begin
            x.imm = ximm; x.fit = xfit; x.tag = t;
            q.push_back(x);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] v, input logic [1:0] e, input logic [3:0] t);
        exp_t m;
        m = model(v, e, t);
        send(v, e, t, m.imm, m.fit);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
        end
        check("drain_done", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [31:0] dv [10] = '{32'hFFFFFFFC, 32'h01FFFFFC, 32'h00000006, 32'h02000000, 32'h000000AB,
                             32'h00000100, 32'h00000FFF, 32'h00001000, 32'h12345678, 32'hFFFFFFFF};
    logic [1:0]  de [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [23:0] di [10] = '{24'hFFFFFF, 24'h7FFFFF, 24'h000001, 24'h800000, 24'h0000AB,
                             24'h000000, 24'h000FFF, 24'h000000, 24'h000000, 24'h000000};
    logic        df [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          done;
        bit          seen;
        int          out0;
        logic [31:0] rv;
        logic [23:0] r24;
        logic [1:0]  re;

        n_checks = 0; n_errors = 0; n_out = 0; exp_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_value = '0; bus.in_extop = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_imm", bus.out_imm, 0);
        check("rst_out_fit", bus.out_fit, 0);
        check("rst_out_tag", bus.out_tag, 0);
`ifdef IMM_ENCODE_STATS_EN
        check("rst_fail_count", fail_count, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Directed encodings, back-to-back.
        for (int i = 0; i < 10; i++) send(dv[i], de[i], i[3:0], di[i], df[i]);
        drain();

        // Random values with random output backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    rv  = $urandom;
                    re  = 2'($urandom_range(0, 3));
                    r24 = 24'($urandom);
                    if (re == 2'd2 && i[0]) rv = {{6{r24[23]}}, r24, 2'b00};
                    if (re != 2'd2 && i[0]) rv = rv & 32'h0000_0FFF;
                    send_m(rv, re, i[3:0]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Backpressure: tags 1..5 with a 4-cycle output stall.
        out0 = n_out;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send_m(i * 4, 2'd2, i[3:0]);
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin seen = 1'b1; break; end
                end
                check("bp_first_valid", seen, 1);
                check("bp_in_ready_low", bus.in_ready, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", bus.in_ready, 0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - out0, 5);

        // Reset with two requests in flight.
        bus.out_ready = 1'b0;
        send_m(32'h0000_0010, 2'd0, 4'd6);
        send_m(32'h0000_0020, 2'd0, 4'd7);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready_after", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_m(32'h0000_0033, 2'd0, 4'd8);
        @(negedge clk);
        check("lat_cycle1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", bus.out_valid, 1);
        drain();

`ifdef IMM_ENCODE_STATS_EN
        do_reset();
        send_m(32'h0000_0100, 2'd0, 4'd1);
        send_m(32'h0000_0005, 2'd2, 4'd2);
        send_m(32'h0000_00FF, 2'd0, 4'd3);
        send_m(32'h0000_1234, 2'd3, 4'd4);
        send_m(32'h0000_0ABC, 2'd1, 4'd5);
        drain();
        check("stats_three", fail_count, 3);
        bus.out_ready = 1'b0;
        send_m(32'h0000_2000, 2'd1, 4'd6);
        repeat (3) begin
            @(negedge clk);
            check("stats_stall_hold", fail_count, 3);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();
        check("stats_four", fail_count, 4);
        check("stats_model", fail_count, exp_fail);
`endif

        check("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_imm_encode
`default_nettype wire
